// File: rtl/data_pipe_pkg.sv
// Shared constants and helpers for the elastic data pipeline.
// Optional flush port is enabled by defining DATA_PIPE_FLUSH_EN.
package data_pipe_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 3;

    function automatic int clog2_plus1(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/data_pipe_stage.sv
// One elastic pipeline stage: valid flag plus data register.
// Data is only written by a valid incoming beat, so bubbles keep old data.
module data_pipe_stage #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             load_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_o <= 1'b0;
            data_o  <= RESET_VALUE;
        end else if (flush_i) begin
            valid_o <= 1'b0;
        end else if (load_i) begin
            valid_o <= valid_i;
            if (valid_i) begin
                data_o <= data_i;
            end
        end
    end

endmodule

// File: rtl/data_pipe.sv
// Elastic register pipeline with valid/ready handshake and occupancy count.
// Define DATA_PIPE_FLUSH_EN to add the flush_i port.
module data_pipe
    import data_pipe_pkg::*;
#(
    parameter int               WIDTH       = DEF_WIDTH,
    parameter int               DEPTH       = DEF_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
`ifdef DATA_PIPE_FLUSH_EN
    input  logic                             flush_i,
`endif
    input  logic                             valid_i,
    output logic                             ready_o,
    input  logic [WIDTH-1:0]                 data_i,
    output logic                             valid_o,
    input  logic                             ready_i,
    output logic [WIDTH-1:0]                 data_o,
    output logic [clog2_plus1(DEPTH)-1:0]    count_o
);

    localparam int CW = clog2_plus1(DEPTH);

    if (WIDTH == 0 || DEPTH == 0) begin : g_param_chk
        $error("data_pipe: WIDTH and DEPTH must be non-zero");
    end

    logic             flush;
    logic [DEPTH-1:0] vld;
    logic [DEPTH:0]   acc;
    logic [WIDTH-1:0] stg_data [DEPTH];
    logic             xfer_in;
    logic             xfer_out;

`ifdef DATA_PIPE_FLUSH_EN
    assign flush = flush_i;
`else
    assign flush = 1'b0;
`endif

    // A stage can take a beat if it is empty or its successor accepts.
    always_comb begin
        acc        = '0;
        acc[DEPTH] = ready_i;
        for (int n = DEPTH - 1; n >= 0; n--) begin
            acc[n] = !vld[n] | acc[n+1];
        end
    end

    for (genvar n = 0; n < DEPTH; n++) begin : g_stage
        logic             in_vld;
        logic [WIDTH-1:0] in_data;

        if (n == 0) begin : g_head
            assign in_vld  = valid_i;
            assign in_data = data_i;
        end else begin : g_body
            assign in_vld  = vld[n-1];
            assign in_data = stg_data[n-1];
        end

        data_pipe_stage #(
            .WIDTH       (WIDTH),
            .RESET_VALUE (RESET_VALUE)
        ) u_stage (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .flush_i (flush),
            .load_i  (acc[n]),
            .valid_i (in_vld),
            .data_i  (in_data),
            .valid_o (vld[n]),
            .data_o  (stg_data[n])
        );
    end

    assign ready_o  = acc[0] & !flush;
    assign valid_o  = vld[DEPTH-1];
    assign data_o   = stg_data[DEPTH-1];
    assign xfer_in  = valid_i & ready_o;
    assign xfer_out = valid_o & ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i || flush) begin
            count_o <= '0;
        end else begin
            count_o <= count_o + CW'(xfer_in) - CW'(xfer_out);
        end
    end

endmodule

// File: tb/tb_data_pipe.sv
// Scoreboard bench for data_pipe: accepted beats queue up, output beats pop.
// Flush scenario runs only when DATA_PIPE_FLUSH_EN is defined.
module tb_data_pipe;
    import data_pipe_pkg::*;

    localparam int W  = DEF_WIDTH;
    localparam int D  = DEF_DEPTH;
    localparam int CW = clog2_plus1(D);

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          flush_i;
    logic          valid_i;
    logic          ready_o;
    logic [W-1:0]  data_i;
    logic          valid_o;
    logic          ready_i;
    logic [W-1:0]  data_o;
    logic [CW-1:0] count_o;

    int            checks = 0;
    int            errors = 0;
    logic [W-1:0]  exp_q [$];

    data_pipe #(
        .WIDTH       (W),
        .DEPTH       (D),
        .RESET_VALUE ('0)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
`ifdef DATA_PIPE_FLUSH_EN
        .flush_i (flush_i),
`endif
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_i  (data_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (data_o),
        .count_o (count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // Input side: record each beat the pipe accepts at the coming edge.
    always @(negedge clk_i) begin
        if (rst_i || flush_i) begin
            exp_q.delete();
        end else if (valid_i && ready_o) begin
            exp_q.push_back(data_i);
        end
    end

    // Output side: every beat leaving must be the oldest accepted one.
    always @(negedge clk_i) begin
        if (!rst_i && !flush_i && valid_o && ready_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_beat: got 0x%0h expected none", data_o);
            end else begin
                chk("out_beat", int'(data_o), int'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_i   = 1'b1;
        flush_i = 1'b0;
        valid_i = 1'b1;
        data_i  = 8'hAA;
        ready_i = 1'b1;
        step(2);
        chk("rst_valid", int'(valid_o), 0);
        chk("rst_data", int'(data_o), 0);
        chk("rst_count", int'(count_o), 0);
        rst_i   = 1'b0;
        valid_i = 1'b0;
        step();
        chk("rst_ready", int'(ready_o), 1);

        // streaming, ready_i high
        for (int i = 1; i <= 16; i++) begin
            valid_i = 1'b1;
            data_i  = W'(i);
            step();
            chk("str_valid", int'(valid_o), (i >= 3) ? 1 : 0);
            if (i >= 3) chk("str_data", int'(data_o), i - 2);
            chk("str_count", int'(count_o), (i < 3) ? i : 3);
            chk("str_ready", int'(ready_o), 1);
        end
        valid_i = 1'b0;
        step(3);
        chk("str_drain", int'(count_o), 0);

        // back-pressure
        ready_i = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            valid_i = 1'b1;
            data_i  = W'(i);
            step();
            chk("bp_count", int'(count_o), i);
        end
        chk("bp_ready_low", int'(ready_o), 0);
        data_i = 8'h04;
        step(2);
        chk("bp_hold_count", int'(count_o), 3);
        chk("bp_hold_ready", int'(ready_o), 0);
        chk("bp_hold_data", int'(data_o), 1);
        ready_i = 1'b1;
        step();
        data_i = 8'h05;
        step();
        chk("bp_swap_count", int'(count_o), 3);
        valid_i = 1'b0;
        step(4);
        chk("bp_drain", int'(count_o), 0);

        // bubble collapse
        ready_i = 1'b0;
        valid_i = 1'b1;
        data_i  = 8'h21;
        step();
        chk("bub_count1", int'(count_o), 1);
        valid_i = 1'b0;
        step(2);
        chk("bub_valid", int'(valid_o), 1);
        chk("bub_data", int'(data_o), 8'h21);
        chk("bub_ready", int'(ready_o), 1);
        valid_i = 1'b1;
        data_i  = 8'h22;
        step();
        chk("bub_count2", int'(count_o), 2);
        valid_i = 1'b0;
        step();
        valid_i = 1'b1;
        data_i  = 8'h23;
        step();
        chk("bub_count3", int'(count_o), 3);
        chk("bub_full", int'(ready_o), 0);

        // full with simultaneous in/out
        ready_i = 1'b1;
        data_i  = 8'h24;
        #1;
        chk("full_ready", int'(ready_o), 1);
        step();
        chk("full_count", int'(count_o), 3);
        valid_i = 1'b0;
        step(3);
        chk("full_drain", int'(count_o), 0);

`ifdef DATA_PIPE_FLUSH_EN
        ready_i = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            valid_i = 1'b1;
            data_i  = W'(8'h30 + i);
            step();
        end
        flush_i = 1'b1;
        data_i  = 8'h34;
        #1;
        chk("fl_ready", int'(ready_o), 0);
        chk("fl_pre_valid", int'(valid_o), 1);
        step();
        flush_i = 1'b0;
        valid_i = 1'b0;
        chk("fl_valid", int'(valid_o), 0);
        chk("fl_count", int'(count_o), 0);
        chk("fl_data_held", int'(data_o), 8'h31);
`endif

        // reset mid-stream
        ready_i = 1'b0;
        valid_i = 1'b1;
        data_i  = 8'h41;
        step();
        data_i = 8'h42;
        step();
        chk("mid_count", int'(count_o), 2);
        rst_i = 1'b1;
        step();
        rst_i   = 1'b0;
        valid_i = 1'b0;
        chk("mid_rst_count", int'(count_o), 0);
        chk("mid_rst_valid", int'(valid_o), 0);
        chk("mid_rst_data", int'(data_o), 0);
        ready_i = 1'b1;
        step(4);
        chk("end_valid", int'(valid_o), 0);
        chk("end_queue", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
